// File: rtl/toy_bus_pkg.sv
// Shared definitions for the toy bus memory slave.
//   OP_RD / OP_WR : request/response opcode encodings
//   rsp_entry_t   : response entry sized for the widest supported configuration.
//                   Instances use the low DATA_W / SB_W / ID_W bits of each field.
`timescale 1ns/1ps
package toy_bus_pkg;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int RSP_MAX_DATA_W = 1024;
  localparam int RSP_MAX_SB_W   = 64;
  localparam int RSP_MAX_ID_W   = 16;

  typedef struct packed {
    logic [RSP_MAX_DATA_W-1:0] data;
    logic [RSP_MAX_SB_W-1:0]   sideband;
    logic [RSP_MAX_ID_W-1:0]   src_id;
    logic                      opcode;
  } rsp_entry_t;

endpackage

// File: rtl/toy_bus_sync_fifo.sv
// Synchronous FIFO used as the response queue.
//   clk, rst_n      : clock, async active-low reset (clears pointers/count)
//   wr_en, wr_data  : push
//   rd_en, rd_data  : pop; rd_data shows the head entry (first-word fall-through)
//   empty, full     : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally. Push and pop in the
// same cycle are allowed at any occupancy; the caller guarantees no overflow.
`timescale 1ns/1ps
module toy_bus_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/toy_bus_mem_slv_pipe.sv
// Toy bus slave in front of a fixed-latency synchronous memory.
//   clk, rst_n           : clock, async active-low reset
//   req_*                : request channel (valid/ready), opcode 0 = read, 1 = write
//   ack_*                : response channel (valid/ready), served from a response FIFO
//   mem_*                : memory port; read data returns RD_LAT cycles after mem_en
// Reads travel an RD_LAT-deep tag pipeline and land in the response FIFO together
// with the memory read data. A credit counter covers FIFO entries plus reads still
// in the pipeline, so the FIFO can never overflow and req_rdy is simply credit != 0.
// Build option TOY_BUS_MEM_WR_ACK_EN: writes also take a credit and return an ack
// (opcode 1, zero data, request sideband). Without it writes are fire-and-forget.
`timescale 1ns/1ps
module toy_bus_mem_slv_pipe
  import toy_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int MEM_AW    = 24,
  parameter int ID_W      = 4,
  parameter int SB_W      = 10,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4,
  parameter int NODE_ID   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                req_opcode,
  input  logic [ID_W-1:0]     req_src_id,
  input  logic [ID_W-1:0]     req_tgt_id,
  input  logic [SB_W-1:0]     req_sideband,
  output logic                ack_vld,
  input  logic                ack_rdy,
  output logic                ack_opcode,
  output logic [DATA_W-1:0]   ack_data,
  output logic [SB_W-1:0]     ack_sideband,
  output logic [ID_W-1:0]     ack_src_id,
  output logic [ID_W-1:0]     ack_tgt_id,
  output logic                mem_en,
  output logic                mem_wr_en,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_byte_en,
  output logic [SB_W-1:0]     mem_req_sideband,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  logic [SB_W-1:0]     mem_ack_sideband
);

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int CR_W   = $clog2(RSP_DEPTH + 1);
  localparam int FIFO_W = DATA_W + SB_W + ID_W + 1;

  logic              accept;
  logic              consume;
  logic              pop;
  logic [CR_W-1:0]   credit;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_op;
  logic [ID_W-1:0]   pipe_src [RD_LAT];
  rsp_entry_t        rsp_push;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic              unused_ok;

  assign req_rdy = (credit != '0);
  assign accept  = req_vld && req_rdy;
  assign pop     = ack_vld && ack_rdy;

`ifdef TOY_BUS_MEM_WR_ACK_EN
  assign consume = accept;
`else
  assign consume = accept && (req_opcode == OP_RD);
`endif

  assign mem_en           = accept;
  assign mem_wr_en        = accept && (req_opcode == OP_WR);
  assign mem_addr         = req_addr[OFF_W+MEM_AW-1:OFF_W];
  assign mem_wr_data      = req_data;
  assign mem_wr_byte_en   = req_strb;
  assign mem_req_sideband = req_sideband;

  // Only valids are reset; tags travelling with them are don't-care when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= consume;
      for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

`ifdef TOY_BUS_MEM_WR_ACK_EN
  logic [SB_W-1:0] pipe_sb [RD_LAT];
`endif

  always_ff @(posedge clk) begin
    pipe_src[0] <= req_src_id;
    pipe_op[0]  <= req_opcode;
`ifdef TOY_BUS_MEM_WR_ACK_EN
    pipe_sb[0]  <= req_sideband;
`endif
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_src[i] <= pipe_src[i-1];
      pipe_op[i]  <= pipe_op[i-1];
`ifdef TOY_BUS_MEM_WR_ACK_EN
      pipe_sb[i]  <= pipe_sb[i-1];
`endif
    end
  end

  always_comb begin
    rsp_push                   = '0;
    rsp_push.opcode            = pipe_op[RD_LAT-1];
    rsp_push.src_id[ID_W-1:0]  = pipe_src[RD_LAT-1];
`ifdef TOY_BUS_MEM_WR_ACK_EN
    if (pipe_op[RD_LAT-1] == OP_WR) begin
      rsp_push.sideband[SB_W-1:0] = pipe_sb[RD_LAT-1];
    end else begin
      rsp_push.data[DATA_W-1:0]   = mem_rd_data;
      rsp_push.sideband[SB_W-1:0] = mem_ack_sideband;
    end
`else
    rsp_push.data[DATA_W-1:0]   = mem_rd_data;
    rsp_push.sideband[SB_W-1:0] = mem_ack_sideband;
`endif
  end

  assign fifo_wdata = {rsp_push.data[DATA_W-1:0], rsp_push.sideband[SB_W-1:0],
                       rsp_push.src_id[ID_W-1:0], rsp_push.opcode};

  // Credit moves only when exactly one of take/return happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CR_W'(RSP_DEPTH);
    end else if (consume && !pop) begin
      credit <= credit - 1'b1;
    end else if (pop && !consume) begin
      credit <= credit + 1'b1;
    end
  end

  toy_bus_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe_vld[RD_LAT-1]),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign ack_vld    = !fifo_empty;
  assign ack_src_id = ID_W'(NODE_ID);
  assign {ack_data, ack_sideband, ack_tgt_id, ack_opcode} = fifo_rdata;

  // Address offset/high bits, target id, the struct's spare upper bits and the
  // FIFO full flag have no function here.
  assign unused_ok = ^{req_addr, req_tgt_id, rsp_push, fifo_full};

endmodule

// File: tb/tb_toy_bus_mem_slv_pipe.sv
// Scoreboard bench: instance 0 runs RD_LAT=1, instance 1 runs RD_LAT=3.
// Stimulus pushes expected acks on accept; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_toy_bus_mem_slv_pipe;

  localparam int DW   = 256;
  localparam int SW   = 10;
  localparam int IW   = 4;
  localparam int MAW  = 24;
  localparam int BW   = DW / 8;
  localparam int NODE = 5;
`ifdef TOY_BUS_MEM_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic          op;
    logic [IW-1:0] tgt;
    logic [SW-1:0] sb;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic          req_vld [2];
  logic          req_rdy [2];
  logic [31:0]   req_addr [2];
  logic [BW-1:0] req_strb [2];
  logic [DW-1:0] req_data [2];
  logic          req_opcode [2];
  logic [IW-1:0] req_src_id [2];
  logic [IW-1:0] req_tgt_id [2];
  logic [SW-1:0] req_sideband [2];
  logic          ack_vld [2];
  logic          ack_rdy [2];
  logic          ack_opcode [2];
  logic [DW-1:0] ack_data [2];
  logic [SW-1:0] ack_sideband [2];
  logic [IW-1:0] ack_src_id [2];
  logic [IW-1:0] ack_tgt_id [2];
  logic          mem_en [2];
  logic          mem_wr_en [2];
  logic [MAW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wr_data [2];
  logic [BW-1:0] mem_wr_byte_en [2];
  logic [SW-1:0] mem_req_sideband [2];
  logic [DW-1:0] mem_rd_data [2];
  logic [SW-1:0] mem_ack_sideband [2];

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   acks_seen = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t held [2];
  bit   hold_pend [2];

  function automatic logic [DW-1:0] mem_word(input logic [MAW-1:0] a);
    return {8{8'hD0, a}};
  endfunction

  function automatic logic [SW-1:0] mem_sb(input logic [MAW-1:0] a);
    return a[SW-1:0] ^ 10'h2A5;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [MAW-1:0] a_sh [LAT];

    // Memory model: data for the address presented LAT cycles earlier.
    always @(posedge clk) begin
      a_sh[0] <= mem_addr[g];
      for (int i = 1; i < LAT; i++) a_sh[i] <= a_sh[i-1];
    end
    assign mem_rd_data[g]      = mem_word(a_sh[LAT-1]);
    assign mem_ack_sideband[g] = mem_sb(a_sh[LAT-1]);

    toy_bus_mem_slv_pipe #(.RD_LAT(LAT), .NODE_ID(NODE)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_vld          (req_vld[g]),
      .req_rdy          (req_rdy[g]),
      .req_addr         (req_addr[g]),
      .req_strb         (req_strb[g]),
      .req_data         (req_data[g]),
      .req_opcode       (req_opcode[g]),
      .req_src_id       (req_src_id[g]),
      .req_tgt_id       (req_tgt_id[g]),
      .req_sideband     (req_sideband[g]),
      .ack_vld          (ack_vld[g]),
      .ack_rdy          (ack_rdy[g]),
      .ack_opcode       (ack_opcode[g]),
      .ack_data         (ack_data[g]),
      .ack_sideband     (ack_sideband[g]),
      .ack_src_id       (ack_src_id[g]),
      .ack_tgt_id       (ack_tgt_id[g]),
      .mem_en           (mem_en[g]),
      .mem_wr_en        (mem_wr_en[g]),
      .mem_addr         (mem_addr[g]),
      .mem_wr_data      (mem_wr_data[g]),
      .mem_wr_byte_en   (mem_wr_byte_en[g]),
      .mem_req_sideband (mem_req_sideband[g]),
      .mem_rd_data      (mem_rd_data[g]),
      .mem_ack_sideband (mem_ack_sideband[g])
    );
  end

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int g);
    exp_t cur;
    exp_t e;
    int   qs;
    cur = {ack_opcode[g], ack_tgt_id[g], ack_sideband[g], ack_data[g]};
    if (!ack_vld[g]) begin
      hold_pend[g] = 1'b0;
      return;
    end
    if (hold_pend[g]) chk("ack_hold", cur, held[g]);
    if (ack_rdy[g]) begin
      hold_pend[g] = 1'b0;
      acks_seen++;
      qs = (g == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ack_unexpected inst %0d: got ack tgt %0d expected none", g, ack_tgt_id[g]);
      end else begin
        if (g == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("ack_op",   ack_opcode[g],   e.op);
        chk("ack_tgt",  ack_tgt_id[g],   e.tgt);
        chk("ack_sb",   ack_sideband[g], e.sb);
        chk("ack_data", ack_data[g],     e.data);
        chk("ack_src",  ack_src_id[g],   NODE);
      end
    end else begin
      hold_pend[g] = 1'b1;
      held[g]      = cur;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end else begin
      hold_pend[0] = 1'b0;
      hold_pend[1] = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after accept or after max_wait cycles.
  task automatic send(input int g, input logic op, input logic [31:0] addr,
                      input logic [IW-1:0] src, input logic [SW-1:0] sb,
                      input logic [BW-1:0] strb, input logic [DW-1:0] data,
                      input bit exp_ack, input int max_wait, output bit acc);
    exp_t e;
    acc = 1'b0;
    req_vld[g]      = 1'b1;
    req_opcode[g]   = op;
    req_addr[g]     = addr;
    req_src_id[g]   = src;
    req_tgt_id[g]   = 4'hE;
    req_sideband[g] = sb;
    req_strb[g]     = strb;
    req_data[g]     = data;
    for (int n = 0; n < max_wait && !acc; n++) begin
      @(negedge clk);
      if (req_rdy[g]) begin
        chk("mem_en",    mem_en[g],           1'b1);
        chk("mem_wr_en", mem_wr_en[g],        op);
        chk("mem_addr",  mem_addr[g],         addr[28:5]);
        chk("mem_req_sb", mem_req_sideband[g], sb);
        if (op) begin
          chk("mem_byte_en", mem_wr_byte_en[g], strb);
          chk("mem_wr_data", mem_wr_data[g],    data);
        end
        @(posedge clk);
        acc = 1'b1;
        if (exp_ack) begin
          if (op) begin
            e.op = 1'b1; e.tgt = src; e.sb = sb; e.data = '0;
          end else begin
            e.op = 1'b0; e.tgt = src; e.sb = mem_sb(addr[28:5]); e.data = mem_word(addr[28:5]);
          end
          if (g == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end else begin
        @(posedge clk);
      end
    end
    #1;
    req_vld[g] = 1'b0;
  endtask

  // Called at posedge+1 right after the accepting edge; counts cycles to ack_vld.
  task automatic wait_ack(input int g, input int exp_lat, input string name);
    int lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (ack_vld[g]) break;
      @(posedge clk);
      lat++;
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((q0.size() != 0 || q1.size() != 0) && n < 200);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int base;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req_vld[g] = 1'b0; req_opcode[g] = 1'b0; req_addr[g] = '0; req_strb[g] = '0;
      req_data[g] = '0; req_src_id[g] = '0; req_tgt_id[g] = '0; req_sideband[g] = '0;
      ack_rdy[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_vld0", ack_vld[0], 1'b0);
    chk("rst_req_rdy0", req_rdy[0], 1'b1);
    chk("rst_ack_vld1", ack_vld[1], 1'b0);
    chk("rst_req_rdy1", req_rdy[1], 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read at 0x40, src 3: word address 2, ack two cycles later.
    send(0, 1'b0, 32'h0000_0040, 4'd3, 10'h011, '0, '0, 1'b1, 2, acc);
    chk("t1_acc", acc, 1'b1);
    wait_ack(0, 2, "lat_rd1");
    @(posedge clk); #1;
    drain();

    // Back-pressure: four reads fill the credits, the fifth is held off.
    ack_rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, 32'h100 + 32'(i) * 32, 4'(i + 4), 10'(i + 16), '0, '0, 1'b1, 1, acc);
      chk("fill_acc", acc, 1'b1);
    end
    send(0, 1'b0, 32'h200, 4'd9, 10'h0F0, '0, '0, 1'b1, 3, acc);
    chk("fifth_blocked", acc, 1'b0);
    @(negedge clk);
    chk("rdy_full", req_rdy[0], 1'b0);
    @(posedge clk); #1;
    ack_rdy[0] = 1'b1;
    @(negedge clk);
    chk("rdy_at_pop", req_rdy[0], 1'b0);
    @(posedge clk); #1;
    ack_rdy[0] = 1'b0;
    @(negedge clk);
    chk("rdy_after_pop", req_rdy[0], 1'b1);
    @(posedge clk); #1;
    send(0, 1'b0, 32'h200, 4'd9, 10'h0F0, '0, '0, 1'b1, 1, acc);
    chk("fifth_acc", acc, 1'b1);
    ack_rdy[0] = 1'b1;
    drain();

    // RD_LAT=3: three reads, acks in order, first ack four cycles after accept.
    send(1, 1'b0, 32'h20, 4'd1, 10'h101, '0, '0, 1'b1, 2, acc);
    chk("rd3_acc1", acc, 1'b1);
    fork
      wait_ack(1, 4, "lat_rd3");
    join_none
    send(1, 1'b0, 32'h40, 4'd2, 10'h102, '0, '0, 1'b1, 2, acc);
    chk("rd3_acc2", acc, 1'b1);
    send(1, 1'b0, 32'h60, 4'd3, 10'h103, '0, '0, 1'b1, 2, acc);
    chk("rd3_acc3", acc, 1'b1);
    drain();

    // Write: passes through to the memory port; ack only with the write-ack build.
    send(0, 1'b1, 32'h80, 4'd2, 10'h03C, 32'hF, 256'hAA, WR_ACK, 2, acc);
    chk("wr_acc", acc, 1'b1);
`ifdef TOY_BUS_MEM_WR_ACK_EN
    wait_ack(0, 2, "wr_ack_lat");
`else
    repeat (5) begin
      @(negedge clk);
      chk("wr_no_ack", ack_vld[0], 1'b0);
    end
`endif
    @(posedge clk); #1;
    drain();

    // Full response path with a pop and a read accept together every cycle.
    ack_rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, 32'h400 + 32'(i) * 32, 4'(i + 8), 10'(i + 32), '0, '0, 1'b1, 1, acc);
      chk("full_fill_acc", acc, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    ack_rdy[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      send(0, 1'b0, 32'h800 + 32'(i) * 32, 4'(i), 10'(i + 64), '0, '0, 1'b1, 1, acc);
      chk("stream_acc", acc, 1'b1);
    end
    drain();

    // Reset with two reads in flight on the RD_LAT=3 instance.
    send(1, 1'b0, 32'h1000, 4'd6, 10'h0AA, '0, '0, 1'b0, 1, acc);
    chk("rst_rd_acc1", acc, 1'b1);
    send(1, 1'b0, 32'h1020, 4'd7, 10'h0AB, '0, '0, 1'b0, 1, acc);
    chk("rst_rd_acc2", acc, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ack_vld0", ack_vld[0], 1'b0);
    chk("mid_rst_req_rdy0", req_rdy[0], 1'b1);
    chk("mid_rst_ack_vld1", ack_vld[1], 1'b0);
    chk("mid_rst_req_rdy1", req_rdy[1], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    base = acks_seen;
    repeat (8) @(posedge clk);
    chk("no_stale_ack", acks_seen - base, 0);
    #1;
    send(1, 1'b0, 32'h2000, 4'd11, 10'h1C3, '0, '0, 1'b1, 2, acc);
    chk("post_rst_acc", acc, 1'b1);
    wait_ack(1, 4, "post_rst_lat");
    @(posedge clk); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/toy_bus_mem_slv_pipe.md
TOY_BUS_MEM_SLV_PIPE -- requirements
Module: toy_bus_mem_slv_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, data width; power of 2, at least 8; OFF_W = log2(DATA_W/8).
REQ-003 SHALL have parameter MEM_AW, default 24, memory word-address width; OFF_W+MEM_AW <= ADDR_W.
REQ-004 SHALL have parameter ID_W, default 4, source/target id width.
REQ-005 SHALL have parameter SB_W, default 10, sideband width.
REQ-006 SHALL have parameter RD_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-007 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries; power of 2, at least RD_LAT+1.
REQ-008 SHALL have parameter NODE_ID, default 0, value driven on ack_src_id.
REQ-009 SHALL have ports, in order:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_vld / req_rdy  in / out  1 / 1  request handshake.
- req_addr  in  ADDR_W  byte address.
- req_strb  in  DATA_W/8  byte enables.
- req_data  in  DATA_W  write data.
- req_opcode  in  1  0 = read, 1 = write.
- req_src_id, req_tgt_id  in  ID_W  ids.
- req_sideband  in  SB_W  sideband.
- ack_vld / ack_rdy  out / in  1 / 1  response handshake.
- ack_opcode  out  1  response opcode.
- ack_data  out  DATA_W  response data.
- ack_sideband  out  SB_W  response sideband.
- ack_src_id, ack_tgt_id  out  ID_W  response ids.
- mem_en, mem_wr_en  out  1  memory enable, write enable.
- mem_addr  out  MEM_AW  word address.
- mem_wr_data  out  DATA_W  write data.
- mem_wr_byte_en  out  DATA_W/8  byte enables.
- mem_req_sideband  out  SB_W  request sideband.
- mem_rd_data  in  DATA_W  read data.
- mem_ack_sideband  in  SB_W  read sideband, valid with mem_rd_data.

Function
REQ-010 SHALL accept a request on a cycle with req_vld && req_rdy, and only then.
REQ-011 SHALL drive mem_en = req_vld && req_rdy, mem_wr_en = mem_en && req_opcode, mem_addr = req_addr[OFF_W+MEM_AW-1:OFF_W], and pass strb, data and sideband through combinationally.
REQ-012 SHALL carry each accepted read down an RD_LAT-stage valid/src_id/opcode shift pipeline.
REQ-013 SHALL, when the pipeline output is valid, push {mem_rd_data, mem_ack_sideband, src_id, opcode=0} into the response FIFO in that same cycle.
REQ-014 SHALL keep a credit count = RSP_DEPTH - (FIFO occupancy + reads in pipeline), and SHALL drive req_rdy = (credit != 0).
REQ-015 SHALL decrement credit on read accept and increment it on ack pop; both in one cycle leaves it unchanged.
REQ-016 SHALL NOT consume credit for writes; req_rdy still gates write acceptance.
REQ-017 SHALL drive ack_vld = FIFO not empty, with ack_* from the FIFO head, ack_src_id = NODE_ID and ack_tgt_id = the stored src_id.
REQ-018 SHALL pop the FIFO on ack_vld && ack_rdy, and SHALL hold ack_* stable while ack_vld && !ack_rdy.
REQ-019 SHALL allow a push and a pop in the same cycle at any occupancy; the credit scheme makes overflow impossible.
REQ-020 SHALL give a minimum read latency, accept to ack_vld, of RD_LAT+1 cycles.
REQ-021 SHALL return acks in acceptance order.

Reset
REQ-022 SHALL, while rst_n is low, clear pipeline valids, FIFO pointers and occupancy, and set credit = RSP_DEPTH, so that ack_vld = 0 and req_rdy = 1.
REQ-023 SHALL discard in-flight reads when reset is asserted mid-operation; no ack is produced for them.

Configuration
REQ-024 SHALL, with TOY_BUS_MEM_WR_ACK_EN defined, treat writes like reads for credit and acks: each write is pushed after RD_LAT cycles with opcode=1, ack_data = 0 and sideband = req_sideband.
REQ-025 SHALL, without TOY_BUS_MEM_WR_ACK_EN, produce no ack for writes.

Structure
REQ-026 SHALL take the opcode constants OP_RD=0 and OP_WR=1 and the response-entry struct from the shared package toy_bus_pkg.
REQ-027 SHALL implement the response FIFO as a sub-module toy_bus_sync_fifo (parameters WIDTH, DEPTH).

Verification
REQ-028 Read with defaults at addr 0x0000_0040 and src_id 3, ack_rdy = 1 -> mem_addr = 2; ack_vld 2 cycles later with tgt_id 3 and data = mem_rd_data.
REQ-029 Hold ack_rdy = 0 and issue 5 back-to-back reads -> 4 accepted, then req_rdy = 0; after 1 pop, req_rdy = 1 on the next cycle.
REQ-030 RD_LAT=3, reads with src_id 1, 2, 3 -> acks in order with tgt_id 1, 2, 3, first ack 4 cycles after accept.
REQ-031 Write with strb 0xF and data 0xAA -> mem_wr_en = 1 with mem_wr_byte_en = 0xF; no ack without the macro; with the macro, an ack with opcode 1 after RD_LAT+1 cycles.
REQ-032 Assert rst_n low with 2 reads in flight -> ack_vld = 0 and req_rdy = 1; no stale ack after reset is released.
REQ-033 FIFO full with simultaneous pop and read accept -> occupancy stays constant and no data is lost or duplicated.
